// File: rtl/fetch_controller_if.sv
// rtl/fetch_controller_if.sv - fetch controller memory and decode port bundle
//
// Signals:
//   mem_addr     address to the synchronous instruction memory
//   mem_instr    registered memory read data (one cycle after mem_addr)
//   instr_out    instruction presented to decode
//   instr_valid  instr_out valid
//   instr_ready  decode accepts instr_out this cycle
//   pc_out       address of the word on instr_out
// Modports: master = fetch controller, slave = memory/decode side.
interface fetch_controller_if #(
  parameter int ADDR_W = 10
) ();
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_instr;
  logic [31:0]       instr_out;
  logic              instr_valid;
  logic              instr_ready;
  logic [ADDR_W-1:0] pc_out;

  modport master (
    output mem_addr,
    input  mem_instr,
    output instr_out,
    output instr_valid,
    input  instr_ready,
    output pc_out
  );

  modport slave (
    input  mem_addr,
    output mem_instr,
    input  instr_out,
    input  instr_valid,
    output instr_ready,
    input  pc_out
  );
endinterface

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction fetch sequencer with optional RAW interlock
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   start       begin a run (sampled in IDLE/DONE only)
//   bus         fetch_controller_if.master: memory address/data, decode handshake, pc_out
//   busy        high while running
//   done        high after the word at END_ADDR has been accepted
//   bubble_cnt  saturating count of inserted NOP bubbles (zero unless interlock built)
// Build option: FETCH_HAZARD_INTERLOCK_EN enables the read-after-write interlock.
module fetch_controller #(
  parameter int ADDR_W      = 10,
  parameter int START_ADDR  = 0,
  parameter int END_ADDR    = 1023,
  parameter int HAZARD_DIST = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  fetch_controller_if.master bus,
  output logic               busy,
  output logic               done,
  output logic [15:0]        bubble_cnt
);
  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] END_PC   = ADDR_W'(END_ADDR);
  localparam logic [31:0]       NOP_WORD = 32'h41E0_0000;

  if (HAZARD_DIST < 1 || HAZARD_DIST > 7) begin : g_bad_dist
    $error("fetch_controller: HAZARD_DIST must be 1..7");
  end
  if (END_ADDR < START_ADDR) begin : g_bad_range
    $error("fetch_controller: END_ADDR must not be below START_ADDR");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              valid_q;
  logic              accept;
  logic              stall;
  logic              at_end;
  logic              run_entry;

  assign accept    = valid_q & bus.instr_ready;
  assign at_end    = (pc == END_PC);
  assign run_entry = (state != S_RUN) & start;

  // Address runs one word ahead only when the current word leaves; otherwise the
  // memory re-reads the held word so mem_instr stays valid under back-pressure.
  always_comb begin
    bus.mem_addr = START_PC;
    if (valid_q) begin
      if (accept && !stall) bus.mem_addr = at_end ? START_PC : pc + ADDR_W'(1);
      else                  bus.mem_addr = pc;
    end
  end

  assign bus.instr_out   = (valid_q && !stall) ? bus.mem_instr : NOP_WORD;
  assign bus.instr_valid = valid_q;
  assign bus.pc_out      = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= START_PC;
      valid_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_RUN;
            pc      <= START_PC;
            valid_q <= 1'b1;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        S_RUN: begin
          if (accept && !stall) begin
            if (at_end) begin
              state   <= S_DONE;
              valid_q <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              pc <= pc + ADDR_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FETCH_HAZARD_INTERLOCK_EN
  localparam logic [5:0] OP_LOAD  = 6'b010000;
  localparam logic [5:0] OP_STORE = 6'b010001;
  localparam logic [5:0] OP_RTYPE = 6'b001111;

  logic [5:0]                  op;
  logic                        is_nop;
  logic                        src_a_v;
  logic                        src_b_v;
  logic                        dst_v;
  logic [4:0]                  src_a;
  logic [4:0]                  src_b;
  logic [4:0]                  dst;
  // Slot 0 is the most recently accepted slot.
  logic [HAZARD_DIST-1:0]      hist_v;
  logic [HAZARD_DIST-1:0][4:0] hist_r;

  always_comb begin
    op      = bus.mem_instr[31:26];
    is_nop  = (bus.mem_instr == NOP_WORD);
    src_a   = bus.mem_instr[25:21];
    src_b   = bus.mem_instr[20:16];
    src_a_v = !is_nop && (op == OP_LOAD || op == OP_STORE || op == OP_RTYPE);
    src_b_v = !is_nop && (op == OP_STORE || op == OP_RTYPE);
    dst_v   = !is_nop && (op == OP_LOAD || op == OP_RTYPE);
    dst     = (op == OP_RTYPE) ? bus.mem_instr[15:11] : bus.mem_instr[20:16];
    stall   = 1'b0;
    for (int i = 0; i < HAZARD_DIST; i++) begin
      if (hist_v[i] && ((src_a_v && hist_r[i] == src_a) ||
                        (src_b_v && hist_r[i] == src_b))) begin
        stall = 1'b1;
      end
    end
    if (!valid_q) stall = 1'b0;
  end

  // A bubble occupies a slot like any other accept but carries no destination.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_v     <= '0;
      hist_r     <= '0;
      bubble_cnt <= '0;
    end else if (run_entry) begin
      hist_v <= '0;
    end else if (accept) begin
      for (int i = HAZARD_DIST - 1; i > 0; i--) begin
        hist_v[i] <= hist_v[i-1];
        hist_r[i] <= hist_r[i-1];
      end
      hist_v[0] <= dst_v & ~stall;
      hist_r[0] <= dst;
      if (stall && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`else
  assign stall      = 1'b0;
  assign bubble_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - scoreboard bench for fetch_controller
module tb_fetch_controller;
  localparam int          ADDR_W     = 10;
  localparam int          START_ADDR = 0;
  localparam int          END_ADDR   = 8;
  localparam int          HD         = 3;
  localparam logic [31:0] NOP        = 32'h41E0_0000;
  localparam logic [5:0]  OP_LOAD    = 6'b010000;
  localparam logic [5:0]  OP_STORE   = 6'b010001;
  localparam logic [5:0]  OP_RTYPE   = 6'b001111;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] bubble_cnt;

  fetch_controller_if #(.ADDR_W(ADDR_W)) bif ();

  fetch_controller #(
    .ADDR_W(ADDR_W), .START_ADDR(START_ADDR), .END_ADDR(END_ADDR), .HAZARD_DIST(HD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bif.master),
    .busy(busy), .done(done), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) bif.mem_instr <= mem[bif.mem_addr];

  int checks      = 0;
  int failures    = 0;
  int exp_bubbles = 0;
  int hold_left   = 0;
  bit hold_used   = 1'b0;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       word;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string act, input string exp);
    checks++;
    failures++;
    $display("FAIL %s: actual=%s expected=%s", name, act, exp);
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input int rs, input int rt, input int rd);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'h010};
  endfunction

  function automatic logic [31:0] gen_word();
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 5))
      0:       w[31:26] = OP_LOAD;
      1:       w[31:26] = OP_STORE;
      2, 3:    w[31:26] = OP_RTYPE;
      4:       w = NOP;
      default: ;
    endcase
    if (w != NOP) begin
      w[25:21] = 5'($urandom_range(0, 3));
      w[20:16] = 5'($urandom_range(0, 3));
      w[15:11] = 5'($urandom_range(0, 3));
    end
    return w;
  endfunction

  // Register usage by instruction class.
  function automatic void decode(input logic [31:0] w, output bit va, output int a,
                                 output bit vb, output int b, output bit vd, output int d);
    va = 0; vb = 0; vd = 0; d = 0;
    a = int'(w[25:21]);
    b = int'(w[20:16]);
    if (w != NOP) begin
      if (w[31:26] == OP_LOAD) begin
        va = 1; vd = 1; d = int'(w[20:16]);
      end else if (w[31:26] == OP_STORE) begin
        va = 1; vb = 1;
      end else if (w[31:26] == OP_RTYPE) begin
        va = 1; vb = 1; vd = 1; d = int'(w[15:11]);
      end
    end
  endfunction

  // Reference: walk the program slot by slot, listing every word decode will accept.
  task automatic build_expected(output int n_slots);
    int   hist[$];
    int   pc;
    int   a, b, d;
    bit   va, vb, vd, stall, fin;
    exp_t e;
    n_slots = 0;
    for (int i = 0; i < HD; i++) hist.push_back(-1);
    pc  = START_ADDR;
    fin = 0;
    while (!fin) begin
      decode(mem[pc], va, a, vb, b, vd, d);
      stall = 0;
`ifdef FETCH_HAZARD_INTERLOCK_EN
      foreach (hist[i]) if (hist[i] >= 0 && ((va && hist[i] == a) || (vb && hist[i] == b))) stall = 1;
`endif
      n_slots++;
      e.pc = ADDR_W'(pc);
      if (stall) begin
        e.word = NOP;
        hist.push_front(-1);
        exp_bubbles++;
      end else begin
        e.word = mem[pc];
        hist.push_front(vd ? d : -1);
        if (pc == END_ADDR) fin = 1;
        else pc++;
      end
      void'(hist.pop_back());
      sb.push_back(e);
    end
  endtask

  task automatic drive_ready(input int mode);
    case (mode)
      0: bif.instr_ready = 1'b1;
      1: bif.instr_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (hold_left > 0) begin
          bif.instr_ready = 1'b0;
          hold_left--;
        end else if (!hold_used && bif.instr_valid && bif.pc_out == ADDR_W'(4)) begin
          bif.instr_ready = 1'b0;
          hold_left = 2;
          hold_used = 1'b1;
        end else begin
          bif.instr_ready = 1'b1;
        end
      end
    endcase
  endtask

  task automatic do_run(input string tag, input int mode, input bit inject);
    int n_slots;
    int k;
    bit fin;
    hold_left = 0;
    hold_used = 1'b0;
    build_expected(n_slots);
    @(posedge clk); #1;
    start = 1'b1;
    drive_ready(mode);
    @(posedge clk); #1;
    start = 1'b0;
    drive_ready(mode);
    @(negedge clk);
    check({tag, "_first_valid"}, bif.instr_valid, 1);
    check({tag, "_first_pc"}, bif.pc_out, START_ADDR);
    check({tag, "_first_busy"}, busy, 1);
    check({tag, "_first_done"}, done, 0);
    k   = 0;
    fin = 0;
    while (!fin && k < 400) begin
      k++;
      @(posedge clk); #1;
      start = inject && (k == 2);
      drive_ready(mode);
      @(negedge clk);
      if (done) fin = 1;
    end
    start = 1'b0;
    if (!fin) begin
      fail({tag, "_timeout"}, "no done", "done");
    end else begin
      if (mode == 0) check({tag, "_cycles"}, k, n_slots);
      check({tag, "_end_busy"}, busy, 0);
      check({tag, "_end_valid"}, bif.instr_valid, 0);
      check({tag, "_end_instr"}, bif.instr_out, NOP);
      check({tag, "_end_addr"}, bif.mem_addr, START_ADDR);
      check({tag, "_sb_left"}, sb.size(), 0);
      check({tag, "_bubble_cnt"}, bubble_cnt, exp_bubbles);
    end
  endtask

  task automatic load_random();
    for (int i = START_ADDR; i <= END_ADDR; i++) mem[i] = gen_word();
  endtask

  exp_t        cur;
  logic        hold_v = 1'b0;
  logic [31:0] hold_w;
  logic [ADDR_W-1:0] hold_pc;

  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && bif.instr_valid) begin
        check("hold_instr", bif.instr_out, hold_w);
        check("hold_pc", bif.pc_out, hold_pc);
      end
      hold_v = 1'b0;
      if (bif.instr_valid) begin
        if (!bif.instr_ready) begin
          hold_v  = 1'b1;
          hold_w  = bif.instr_out;
          hold_pc = bif.pc_out;
        end else if (sb.size() == 0) begin
          fail("accept_unexpected", $sformatf("pc=%0d", bif.pc_out), "no accept");
        end else begin
          cur = sb.pop_front();
          check("accept_pc", bif.pc_out, cur.pc);
          check("accept_word", bif.instr_out, cur.word);
        end
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
    bif.instr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle_mem_addr", bif.mem_addr, START_ADDR);
      check("idle_valid", bif.instr_valid, 0);
      check("idle_instr", bif.instr_out, NOP);
      check("idle_pc", bif.pc_out, START_ADDR);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_bubbles", bubble_cnt, 0);
    end

    load_random(); do_run("seq", 0, 0);
    load_random(); do_run("bp", 2, 0);
    load_random(); do_run("rnd", 1, 1);

    mem[0] = mk(OP_LOAD, 7, 0, 0);
    mem[1] = mk(OP_LOAD, 7, 1, 0);
    mem[2] = mk(OP_RTYPE, 0, 1, 4);
    for (int i = 3; i <= END_ADDR; i++) mem[i] = mk(OP_STORE, 20, 21, 0);
    do_run("h_load", 0, 0);

    mem[0] = mk(OP_RTYPE, 2, 3, 5);
    mem[1] = mk(OP_RTYPE, 4, 5, 6);
    for (int i = 2; i <= END_ADDR; i++) mem[i] = mk(OP_STORE, 20, 21, 0);
    do_run("h_add", 0, 0);

    mem[0] = mk(OP_RTYPE, 9, 9, 10);
    for (int i = 1; i < END_ADDR; i++) mem[i] = mk(OP_STORE, 20, 21, 0);
    mem[END_ADDR] = mk(OP_RTYPE, 20, 21, 9);
    do_run("h_restart_a", 0, 0);
    do_run("h_restart_b", 0, 0);

    for (int r = 0; r < 4; r++) begin
      load_random();
      do_run("rnd_n", 1, r[0]);
    end

    load_random();
    build_expected(n);
    @(posedge clk); #1;
    start = 1'b1;
    bif.instr_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_mem_addr", bif.mem_addr, START_ADDR);
    check("rst_pc", bif.pc_out, START_ADDR);
    check("rst_valid", bif.instr_valid, 0);
    check("rst_instr", bif.instr_out, NOP);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bubbles", bubble_cnt, 0);
    sb.delete();
    exp_bubbles = 0;
    @(posedge clk);
    #3 rst = 1'b0;

    load_random(); do_run("post_rst", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
